// File: rtl/mips32_instr_stream_pkg.sv
// Shared types, opcode constants and field helpers for the MIPS32 instruction feeder.
package mips32_instr_stream_pkg;

  typedef logic [31:0] instr_t;

  localparam instr_t NOP = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic {
    MODE_STREAM,
    MODE_REPLAY
  } mode_t;

  function automatic logic [5:0] opcode(input instr_t i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] rs(input instr_t i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] rt(input instr_t i);
    return i[20:16];
  endfunction

endpackage

// File: rtl/mips32_load_use_chk.sv
// Combinational load-use hazard compare between the last issued word and the buffer head.
// Only built when MIPS32_HAZARD_BUBBLE_EN is defined.
`ifdef MIPS32_HAZARD_BUBBLE_EN
module mips32_load_use_chk
  import mips32_instr_stream_pkg::*;
(
  input  instr_t prev_instr,
  input  instr_t next_instr,
  output logic   hazard
);

  logic [5:0] next_op;
  logic       reads_rt;
  logic       prev_is_load;

  always_comb begin
    next_op      = opcode(next_instr);
    reads_rt     = (next_op == OP_RTYPE) || (next_op == OP_SW) ||
                   (next_op == OP_BEQ)   || (next_op == OP_BNE);
    prev_is_load = (opcode(prev_instr) == OP_LW) && (rt(prev_instr) != '0);
    hazard       = prev_is_load &&
                   ((rs(next_instr) == rt(prev_instr)) ||
                    (reads_rt && (rt(next_instr) == rt(prev_instr))));
  end

endmodule
`endif

// File: rtl/mips32_instr_stream.sv
// Buffered instruction feeder with NOP bubbling, replay looping and issue statistics.
// Optional load-use bubbling and hazard_stall port under MIPS32_HAZARD_BUBBLE_EN.
module mips32_instr_stream
  import mips32_instr_stream_pkg::*;
#(
  parameter int unsigned IW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 16
`ifdef MIPS32_HAZARD_BUBBLE_EN
  , parameter int unsigned LOAD_USE_BUBBLES = 1
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [IW-1:0]            s_instr,
  output logic                     s_ready,
  input  logic                     issue_en,
  input  logic                     replay,
  input  logic                     flush,
  output logic [IW-1:0]            instr_out,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CW-1:0]            issued_cnt,
  output logic [CW-1:0]            bubble_cnt
`ifdef MIPS32_HAZARD_BUBBLE_EN
  , output logic                   hazard_stall
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [IW-1:0] mem [DEPTH];
  ptr_t          wr_ptr, rd_ptr, base_ptr;
  ptr_t          wr_nxt, rd_nxt, base_nxt, rd_inc, lvl_nxt;
  mode_t         mode;
  logic          push, avail, pop;
  logic [IW-1:0] head;

  assign s_ready = !full && !replay;
  assign push    = s_valid && s_ready && !flush;
  assign avail   = (rd_ptr != wr_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign rd_inc  = rd_ptr + 1'b1;

`ifdef MIPS32_HAZARD_BUBBLE_EN
  localparam int unsigned GW = $clog2(LOAD_USE_BUBBLES + 1) + 1;

  logic [IW-1:0] last_real;
  logic [GW-1:0] gap;
  logic          hz_hit, hz_bubble;

  mips32_load_use_chk u_load_use_chk (
    .prev_instr (instr_t'(last_real)),
    .next_instr (instr_t'(head)),
    .hazard     (hz_hit)
  );

  // gap counts bubbles since the last real issue, so idle bubbles also cover the load latency
  assign hz_bubble = avail && hz_hit && (gap < GW'(LOAD_USE_BUBBLES));
  assign pop       = issue_en && avail && !hz_bubble;
`else
  assign pop       = issue_en && avail;
`endif

  always_comb begin
    wr_nxt   = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_nxt   = rd_ptr;
    base_nxt = base_ptr;
    if (pop) begin
      if (replay && (rd_inc == wr_ptr)) rd_nxt = base_ptr;
      else                              rd_nxt = rd_inc;
    end
    // Outside replay base follows the read pointer, which also drops replayed entries on exit.
    unique case (mode)
      MODE_STREAM: base_nxt = replay ? rd_ptr : rd_nxt;
      MODE_REPLAY: base_nxt = replay ? base_ptr : rd_nxt;
      default:     base_nxt = rd_nxt;
    endcase
    if (flush) begin
      wr_nxt   = wr_ptr;
      rd_nxt   = wr_ptr;
      base_nxt = wr_ptr;
    end
    lvl_nxt = wr_nxt - base_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      base_ptr <= '0;
      mode     <= MODE_STREAM;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      base_ptr <= base_nxt;
      mode     <= replay ? MODE_REPLAY : MODE_STREAM;
      level    <= lvl_nxt;
      full     <= (lvl_nxt == ptr_t'(DEPTH));
      empty    <= (lvl_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out   <= IW'(NOP);
      instr_valid <= 1'b0;
      issued_cnt  <= '0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      instr_out   <= IW'(NOP);
      instr_valid <= 1'b0;
    end else if (issue_en) begin
      if (pop) begin
        instr_out   <= head;
        instr_valid <= 1'b1;
        if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
      end else begin
        instr_out   <= IW'(NOP);
        instr_valid <= 1'b0;
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

`ifdef MIPS32_HAZARD_BUBBLE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_real    <= IW'(NOP);
      gap          <= '0;
      hazard_stall <= 1'b0;
    end else if (flush) begin
      last_real    <= IW'(NOP);
      hazard_stall <= 1'b0;
    end else if (issue_en) begin
      if (pop) begin
        last_real    <= head;
        gap          <= '0;
        hazard_stall <= 1'b0;
      end else begin
        if (gap < GW'(LOAD_USE_BUBBLES)) gap <= gap + 1'b1;
        hazard_stall <= hz_bubble;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips32_instr_stream.sv
// Directed bench for mips32_instr_stream: queue-based reference model checked every cycle.
module tb_mips32_instr_stream;

  localparam int DEPTH = 16;
  localparam int LUB   = 1;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_ready, issue_en, replay, flush;
  logic [31:0] s_instr, instr_out;
  logic        instr_valid, full, empty;
  logic [4:0]  level;
  logic [15:0] issued_cnt, bubble_cnt;
`ifdef MIPS32_HAZARD_BUBBLE_EN
  logic        hazard_stall;
`endif

  mips32_instr_stream #(.IW(32), .DEPTH(DEPTH), .CW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_instr     (s_instr),
    .s_ready     (s_ready),
    .issue_en    (issue_en),
    .replay      (replay),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .issued_cnt  (issued_cnt),
    .bubble_cnt  (bubble_cnt)
`ifdef MIPS32_HAZARD_BUBBLE_EN
    , .hazard_stall(hazard_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: mq holds live entries from the replay base onward.
  logic [31:0] mq[$];
  int          ridx;
  logic [31:0] e_out;
  bit          e_valid, e_full, e_hz;
  int          e_issued, e_bubble;
  logic [31:0] m_last;
  int          m_gap;
  int          n_pass = 0;
  int          n_chk  = 0;
  string       phase  = "init";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
  endtask

`ifdef MIPS32_HAZARD_BUBBLE_EN
  function automatic bit m_hazard(input logic [31:0] p, input logic [31:0] n);
    logic [5:0] op;
    op = n[31:26];
    if (p[31:26] != 6'b100011 || p[20:16] == 5'd0) return 1'b0;
    if (n[25:21] == p[20:16]) return 1'b1;
    return (op == 6'd0 || op == 6'b101011 || op == 6'd4 || op == 6'd5) && (n[20:16] == p[20:16]);
  endfunction
`endif

  task automatic tick();
    bit          m_push, hz;
    logic [31:0] hd;
    if (rst) begin
      mq.delete(); ridx = 0; e_out = '0; e_valid = 0; e_hz = 0;
      e_issued = 0; e_bubble = 0; m_last = '0; m_gap = 0;
    end else if (flush) begin
      mq.delete(); ridx = 0; e_out = '0; e_valid = 0; e_hz = 0; m_last = '0;
    end else begin
      m_push = s_valid && !e_full && !replay;
      if (!replay && ridx != 0) begin
        repeat (ridx) void'(mq.pop_front());
        ridx = 0;
      end
      if (issue_en) begin
        hz = 1'b0;
`ifdef MIPS32_HAZARD_BUBBLE_EN
        if (mq.size() > 0) hz = m_hazard(m_last, mq[ridx]) && (m_gap < LUB);
`endif
        if (mq.size() > 0 && !hz) begin
          hd = mq[ridx];
          e_out = hd; e_valid = 1; e_hz = 0; m_last = hd; m_gap = 0;
          if (e_issued != 16'hFFFF) e_issued++;
          if (replay) ridx = (ridx + 1 == mq.size()) ? 0 : ridx + 1;
          else void'(mq.pop_front());
        end else begin
          e_out = '0; e_valid = 0; e_hz = hz;
          if (e_bubble != 16'hFFFF) e_bubble++;
          if (m_gap < LUB) m_gap++;
        end
      end
      if (m_push) mq.push_back(s_instr);
    end
    e_full = (mq.size() == DEPTH);
    @(posedge clk);
    #1;
    chk("instr_out", instr_out, e_out);
    chk("instr_valid", instr_valid, e_valid);
    chk("level", level, mq.size());
    chk("full", full, e_full);
    chk("empty", empty, mq.size() == 0);
    chk("s_ready", s_ready, !e_full && !replay);
    chk("issued_cnt", issued_cnt, e_issued);
    chk("bubble_cnt", bubble_cnt, e_bubble);
`ifdef MIPS32_HAZARD_BUBBLE_EN
    chk("hazard_stall", hazard_stall, e_hz);
`endif
  endtask

  task automatic push_word(input logic [31:0] w);
    s_valid = 1'b1;
    s_instr = w;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] seq [7];
    rst = 1'b1; s_valid = 1'b0; s_instr = '0; issue_en = 1'b0; replay = 1'b0; flush = 1'b0;
    mq.delete(); ridx = 0; e_full = 0;

    phase = "reset";
    tick(); tick();
    rst = 1'b0;

    phase = "stream";
    push_word(32'hA000_000A); push_word(32'hB000_000B); push_word(32'hC000_000C);
    issue_en = 1'b1;
    repeat (6) tick();
    chk("t1_issued", issued_cnt, 3);
    chk("t1_bubble", bubble_cnt, 3);
    issue_en = 1'b0;

    phase = "full";
    for (int i = 0; i < DEPTH; i++) push_word($urandom);
    s_valid = 1'b1; s_instr = 32'h1717_1717;
    tick(); tick();
    chk("t2_full", full, 1);
    chk("t2_ready", s_ready, 0);
    issue_en = 1'b1; tick(); issue_en = 1'b0;
    chk("t2_ready_after_pop", s_ready, 1);
    tick(); s_valid = 1'b0;
    issue_en = 1'b1;
    repeat (DEPTH + 2) tick();
    issue_en = 1'b0;

    phase = "replay";
    seq = '{32'h0000_0111, 32'h0000_0222, 32'h0000_0333, 32'h0000_0111,
            32'h0000_0222, 32'h0000_0333, 32'h0000_0111};
    push_word(seq[0]); push_word(seq[1]); push_word(seq[2]);
    replay = 1'b1; tick();
    issue_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_word", instr_out, seq[i]);
      chk("t3_level", level, 3);
    end
    issue_en = 1'b0; replay = 1'b0; tick();
    chk("t3_exit_level", level, 2);
    issue_en = 1'b1; tick();
    chk("t3_next", instr_out, seq[1]);
    repeat (3) tick();

    phase = "hold_flush";
    issue_en = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h4400_0000 + i);
    issue_en = 1'b1; tick(); tick();
    issue_en = 1'b0;
    repeat (4) tick();
    chk("t4_held", instr_out, 32'h4400_0001);
    for (int i = 0; i < 3; i++) push_word(32'h4500_0000 + i);
    chk("t4_level", level, 5);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4_empty", empty, 1);
    chk("t4_nop", instr_out, 0);
    issue_en = 1'b1; tick(); tick(); issue_en = 1'b0;

    phase = "mid_reset";
    for (int i = 0; i < 8; i++) push_word($urandom);
    replay = 1'b1; issue_en = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; replay = 1'b0; issue_en = 1'b0;
    chk("t5_out", instr_out, 0);
    chk("t5_cnt", issued_cnt, 0);
    chk("t5_level", level, 0);
    tick();
    chk("t5_ready", s_ready, 1);

    phase = "load_use";
    push_word(32'h8D08_0000); push_word(32'h0108_4820);
    issue_en = 1'b1; tick();
    chk("t6_lw", instr_out, 32'h8D08_0000);
    tick();
`ifdef MIPS32_HAZARD_BUBBLE_EN
    chk("t6_bubble", instr_out, 0);
    chk("t6_stall", hazard_stall, 1);
    tick();
`endif
    chk("t6_add", instr_out, 32'h0108_4820);
    repeat (2) tick();
    issue_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
